// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state encoding and mux constants for the subtractive GCD block
package gcd_pkg;

  localparam int GCD_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CALC   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Subtractor operand selects
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Datapath bus source selects
  localparam logic BUS_SUB = 1'b0;
  localparam logic BUS_IN  = 1'b1;

endpackage

// File: rtl/gcd_iter_counter.sv
// rtl/gcd_iter_counter.sv - clearable saturating up-counter with terminal-count flag
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear count to 0 (takes priority over inc)
//   inc      : advance count by one unless already at MAX
//   tc       : count has reached MAX
module gcd_iter_counter import gcd_pkg::*; #(
  parameter int W   = 17,
  parameter int MAX = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count;

  // Saturates at MAX so a stuck loop can never wrap back under the limit
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != MAX_V)) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == MAX_V);

endmodule

// File: rtl/gcd_controller.sv
// rtl/gcd_controller.sv - FSM sequencing operand load and subtract loop of the GCD datapath
// Ports:
//   clk, rst         : clock, synchronous active-high reset (forces IDLE)
//   start            : begin a computation, honoured in IDLE only
//   in_valid/in_ready: operand handshake for data_in on the datapath bus
//   gt, eq, lt       : datapath comparison status of A against B
//   LdA, LdB         : load A / B register from the bus
//   sel1, sel2       : subtractor minuend / subtrahend select (0 = A, 1 = B)
//   sel_in           : bus source (0 = subtractor, 1 = data_in)
//   busy             : any state other than IDLE
//   done, err        : one-cycle completion pulse; err marks iteration-limit abort
module gcd_controller import gcd_pkg::*; #(
  parameter int ITER_W   = 17,
  parameter int MAX_ITER = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_valid,
  output logic in_ready,
  input  logic gt,
  input  logic eq,
  input  logic lt,
  output logic LdA,
  output logic LdB,
  output logic sel1,
  output logic sel2,
  output logic sel_in,
  output logic busy,
  output logic done,
  output logic err
);

  state_t state;
  logic   err_flag;
  logic   iter_tc;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   eq_eff;
  logic   do_gt;
  logic   do_lt;

  // No status bit asserted is illegal; it is folded into eq so the loop ends cleanly
  assign eq_eff = eq | ~(gt | lt);
  assign do_gt  = ~eq_eff & gt & ~iter_tc;
  assign do_lt  = ~eq_eff & ~gt & lt & ~iter_tc;

  assign cnt_clr = (state == IDLE) && start;
  assign cnt_inc = (state == CALC) && (do_gt || do_lt);

  gcd_iter_counter #(
    .W   (ITER_W),
    .MAX (MAX_ITER)
  ) u_iter_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .tc  (iter_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      err_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD_A;
            err_flag <= 1'b0;
          end
        end
        LOAD_A: if (in_valid) state <= LOAD_B;
        LOAD_B: if (in_valid) state <= CALC;
        CALC: begin
          if (eq_eff) begin
            state <= DONE;
          end else if (iter_tc) begin
            err_flag <= 1'b1;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode combinationally: the datapath loads on the same edge the decision is made
  always_comb begin
    LdA      = 1'b0;
    LdB      = 1'b0;
    sel1     = SEL_A;
    sel2     = SEL_A;
    sel_in   = BUS_SUB;
    in_ready = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    busy     = (state != IDLE);
    case (state)
      LOAD_A: begin
        in_ready = 1'b1;
        sel_in   = BUS_IN;
        LdA      = in_valid;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        sel_in   = BUS_IN;
        LdB      = in_valid;
      end
      CALC: begin
        if (do_gt) begin
          sel1 = SEL_A;
          sel2 = SEL_B;
          LdA  = 1'b1;
        end else if (do_lt) begin
          sel1 = SEL_B;
          sel2 = SEL_A;
          LdB  = 1'b1;
        end
      end
      DONE: begin
        done = 1'b1;
        err  = err_flag;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gcd_controller.sv
// tb/tb_gcd_controller.sv - self-checking bench: controller driving a behavioural GCD datapath
module tb_gcd_controller;

  localparam int TB_ITER_W = 11;
  localparam int TB_MAX    = 1000;

  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready;
  logic gt, eq, lt;
  logic LdA, LdB, sel1, sel2, sel_in, busy, done, err;
  logic [15:0] data_in;
  logic [15:0] a_reg = '0;
  logic [15:0] b_reg = '0;
  logic [15:0] sub_a, sub_b, bus;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gcd_controller #(
    .ITER_W   (TB_ITER_W),
    .MAX_ITER (TB_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .gt       (gt),
    .eq       (eq),
    .lt       (lt),
    .LdA      (LdA),
    .LdB      (LdB),
    .sel1     (sel1),
    .sel2     (sel2),
    .sel_in   (sel_in),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Behavioural datapath
  assign sub_a = sel1 ? b_reg : a_reg;
  assign sub_b = sel2 ? b_reg : a_reg;
  assign bus   = sel_in ? data_in : (sub_a - sub_b);
  assign gt    = (a_reg > b_reg);
  assign eq    = (a_reg == b_reg);
  assign lt    = (a_reg < b_reg);

  always @(posedge clk) begin
    if (LdA) a_reg <= bus;
    if (LdB) b_reg <= bus;
  end

  // Event monitor
  int calc_loads  = 0;
  int both_ld     = 0;
  int stall_loads = 0;
  int done_pulses = 0;

  always @(posedge clk) begin
    if (LdA && LdB) both_ld <= both_ld + 1;
    if ((LdA || LdB) && !sel_in) calc_loads <= calc_loads + 1;
    if ((LdA || LdB) && in_ready && !in_valid) stall_loads <= stall_loads + 1;
    if (done) done_pulses <= done_pulses + 1;
  end

  typedef struct {
    logic [15:0] g;
    logic        e;
    int          n;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(input int a, input int b);
    exp_t r;
    int   x;
    int   y;
    x   = a;
    y   = b;
    r.n = 0;
    r.e = 1'b0;
    while (x != y) begin
      if (r.n == TB_MAX) begin
        r.e = 1'b1;
        break;
      end
      if (x > y) x = x - y;
      else       y = y - x;
      r.n++;
    end
    r.g = 16'(x);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic run(input int a, input int b, input int sa, input int sb_n, input bit busy_start);
    exp_t e;
    int   t;
    int   k;
    int   loads0;
    int   stall0;
    int   done0;
    sb.push_back(model(a, b));
    loads0 = calc_loads;
    stall0 = stall_loads;
    done0  = done_pulses;
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    t        = 0;
    #1 chk("idle_busy", busy, 0);
    @(negedge clk); t++;
    start = 1'b0;
    for (int i = 0; i < sa; i++) begin
      in_valid = 1'b0;
      #1 chk("stall_a", {in_ready, LdA, LdB}, 3'b100);
      @(negedge clk); t++;
    end
    in_valid = 1'b1;
    data_in  = 16'(a);
    #1 chk("load_a", {in_ready, LdA, LdB, sel_in}, 4'b1101);
    @(negedge clk); t++;
    for (int i = 0; i < sb_n; i++) begin
      in_valid = 1'b0;
      #1 chk("stall_b", {in_ready, LdA, LdB}, 3'b100);
      @(negedge clk); t++;
    end
    in_valid = 1'b1;
    data_in  = 16'(b);
    #1 chk("load_b", {in_ready, LdA, LdB, sel_in}, 4'b1011);
    @(negedge clk); t++;
    in_valid = 1'b0;
    if (busy_start) start = 1'b1;
    #1;
    k = 0;
    while (done !== 1'b1 && k < TB_MAX + 10) begin
      @(negedge clk); t++; k++;
      start = 1'b0;
      #1;
    end
    e = sb.pop_front();
    chk("done_seen", done, 1);
    chk("latency", t, 4 + sa + sb_n + e.n);
    chk("err", err, e.e);
    if (!e.e) chk("result", a_reg, e.g);
    if (busy_start) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 chk("back_idle", {busy, done, in_ready, LdA, LdB}, 0);
    chk("calc_loads", calc_loads - loads0, e.n);
    chk("stall_loads", stall_loads - stall0, 0);
    chk("one_done", done_pulses - done0, 1);
    chk("ld_exclusive", both_ld, 0);
  endtask

  initial begin
    int done0;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    repeat (3) @(negedge clk);
    #1 chk("reset_outputs", {in_ready, LdA, LdB, sel1, sel2, sel_in, busy, done, err}, 0);
    rst = 1'b0;

    run(12, 18, 0, 0, 1'b0);
    run(143, 143, 0, 0, 1'b0);
    run(21, 14, 3, 2, 1'b0);
    run(0, 5, 0, 0, 1'b0);
    run(1, TB_MAX + 1, 0, 0, 1'b0);
    run(35, 15, 1, 0, 1'b1);

    // Reset in the middle of a non-converging CALC loop
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; data_in = 16'd0;
    @(negedge clk); data_in = 16'd5;
    @(negedge clk); in_valid = 1'b0;
    repeat (20) @(negedge clk);
    #1 chk("mid_calc_busy", busy, 1);
    done0 = done_pulses;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_outputs", {in_ready, LdA, LdB, sel1, sel2, sel_in, busy, done, err}, 0);
    repeat (3) @(negedge clk);
    chk("no_done_after_rst", done_pulses - done0, 0);

    run(12, 18, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
